// File: rtl/card_shoe.sv
// Multi-deck card shoe: fills NUM_DECKS x 52 card codes, Fisher-Yates shuffles them
// with a free-running Galois LFSR, then deals one registered card per pip.
module card_shoe #(
  parameter int          NUM_DECKS = 1,
  parameter logic [15:0] SEED      = 16'hACE1,
  localparam int         N         = 52 * NUM_DECKS,
  localparam int         IDX_W     = $clog2(N),
  localparam int         CNT_W     = $clog2(N + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pip,
  input  logic             shuffle,
  output logic [3:0]       number,
  output logic [1:0]       suits,
  output logic             valid,
  output logic             empty,
  output logic             busy,
  output logic [CNT_W-1:0] remaining
);

  localparam logic [15:0]      SEED_EFF = (SEED == 16'h0000) ? 16'hACE1 : SEED;
  localparam logic [IDX_W-1:0] LAST     = IDX_W'(N - 1);
  localparam logic [CNT_W-1:0] N_CNT    = CNT_W'(N);

  typedef enum logic [1:0] {FILL, SHUF, READY} state_t;

  state_t           state;
  logic [15:0]      lfsr;
  logic [15:0]      lfsr_next;
  logic [IDX_W-1:0] k;
  logic [IDX_W-1:0] i;
  logic [IDX_W-1:0] j;
  logic [IDX_W-1:0] ptr;
  logic [5:0]       fill_code;
  logic             fill_en;
  logic             swap_en;
  logic [5:0]       mem [N];

  always_comb begin
    lfsr_next = {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
    j         = lfsr[IDX_W-1:0];
    fill_en   = (state == FILL);
    swap_en   = (state == SHUF) && (j <= i);
  end

  // Card store has no reset: contents are rebuilt by FILL after every reset.
  always_ff @(posedge clk) begin
    if (fill_en) begin
      mem[k] <= fill_code;
    end else if (swap_en) begin
      mem[i] <= mem[j];
      mem[j] <= mem[i];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= FILL;
      lfsr      <= SEED_EFF;
      k         <= '0;
      i         <= LAST;
      ptr       <= '0;
      fill_code <= 6'd4;
      number    <= '0;
      suits     <= '0;
      valid     <= 1'b0;
      empty     <= 1'b0;
      busy      <= 1'b1;
      remaining <= N_CNT;
    end else begin
      lfsr   <= lfsr_next;
      valid  <= 1'b0;
      number <= '0;
      suits  <= '0;
      case (state)
        FILL: begin
          fill_code <= (fill_code == 6'd55) ? 6'd4 : fill_code + 6'd1;
          k         <= k + IDX_W'(1);
          if (k == LAST) begin
            state <= SHUF;
            i     <= LAST;
            k     <= '0;
          end
        end
        SHUF: begin
          // Candidates above i are rejected; the LFSR supplies a fresh one next cycle.
          if (j <= i) begin
            i <= i - IDX_W'(1);
            if (i == IDX_W'(1)) begin
              state <= READY;
              busy  <= 1'b0;
            end
          end
        end
        READY: begin
          if (shuffle) begin
            state     <= SHUF;
            i         <= LAST;
            ptr       <= '0;
            empty     <= 1'b0;
            remaining <= N_CNT;
            busy      <= 1'b1;
          end else if (pip && !empty) begin
            number    <= mem[ptr][5:2];
            suits     <= mem[ptr][1:0];
            valid     <= 1'b1;
            ptr       <= ptr + IDX_W'(1);
            remaining <= remaining - CNT_W'(1);
            if (remaining == CNT_W'(1)) empty <= 1'b1;
          end
        end
        default: state <= FILL;
      endcase
    end
  end

endmodule
